ping_responder: RTL and testbench



---
 rtl/ping_pkg.sv | 27 ++
 rtl/ping_responder_if.sv | 24 ++
 rtl/ping_sync.sv | 32 +++
 rtl/ping_responder.sv | 186 ++++++++++++++++++
 tb/tb_ping_responder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ping_pkg.sv
// Shared definitions for the PING ultrasonic sensor responder: state
// encoding, default timing constants and counter widths.
package ping_pkg;

  localparam int CNT_W  = 16;
  localparam int INCH_W = 8;

  localparam int DEF_CYC_PER_INCH = 58;
  localparam int DEF_MIN_TRIG_CYC = 1;
  localparam int DEF_MAX_TRIG_CYC = 8;
  localparam int DEF_HOLDOFF_CYC  = 293;
  localparam int DEF_RECOVER_CYC  = 78;
  localparam int DEF_MAX_INCH     = 200;

  // Fixed "no object" echo width used when out-of-range reporting is built in.
  localparam int NO_OBJ_CYC = 7227;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAITLOW,
    HOLDOFF,
    ECHO,
    RECOVER
  } state_t;

endpackage

// File: rtl/ping_responder_if.sv
// Pin and control bundle between a PING host (or bench) and the responder.
// pulse_in is the resolved pin value; pulse_out/pulse_en form the tri-state.
interface ping_responder_if;
  import ping_pkg::*;

  logic              pulse_in;
  logic              pulse_out;
  logic              pulse_en;
  logic [INCH_W-1:0] distance;
  logic              enable;
  logic              busy;
  logic              bad_trig;

  modport slave (
    input  pulse_in, distance, enable,
    output pulse_out, pulse_en, busy, bad_trig
  );

  modport master (
    output pulse_in, distance, enable,
    input  pulse_out, pulse_en, busy, bad_trig
  );

endinterface

// File: rtl/ping_sync.sv
// Two-flop synchronizer for the shared pin with registered edge strobes.
// rise/fall assert in the same cycle that level changes.
module ping_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;

  // Synchronize the pin and derive edge strobes aligned with sync_p1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      rise    <= sync_p0 & ~sync_p1;
      fall    <= ~sync_p0 & sync_p1;
    end
  end

  assign level = sync_p1;

endmodule

// File: rtl/ping_responder.sv
// PING sensor responder: accepts a host trigger pulse on the shared pin,
// waits a fixed holdoff, then drives an echo whose width is the latched
// distance times CYC_PER_INCH (nested inch/cycle counters, no multiplier).
// Optional macro PING_RESP_OUTRANGE_EN: distances above MAX_INCH give a
// fixed NO_OBJ_CYC echo instead of clamping to MAX_INCH.
module ping_responder
  import ping_pkg::*;
#(
  parameter int unsigned CYC_PER_INCH = DEF_CYC_PER_INCH,
  parameter int unsigned MIN_TRIG_CYC = DEF_MIN_TRIG_CYC,
  parameter int unsigned MAX_TRIG_CYC = DEF_MAX_TRIG_CYC,
  parameter int unsigned HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
  parameter int unsigned RECOVER_CYC  = DEF_RECOVER_CYC,
  parameter int unsigned MAX_INCH     = DEF_MAX_INCH
) (
  input  logic        clk,
  input  logic        reset,
  ping_responder_if.slave bus
);

  localparam int unsigned CNT_LIM = (1 << CNT_W) - 1;

  if ((CYC_PER_INCH * MAX_INCH) > CNT_LIM || HOLDOFF_CYC > CNT_LIM ||
      RECOVER_CYC > CNT_LIM || MAX_TRIG_CYC >= CNT_LIM ||
      NO_OBJ_CYC > CNT_LIM || MAX_INCH > 255 || MAX_INCH == 0 ||
      CYC_PER_INCH == 0 || HOLDOFF_CYC == 0 || RECOVER_CYC == 0 ||
      MIN_TRIG_CYC > MAX_TRIG_CYC) begin : g_param_check
    $error("ping_responder: timing parameters do not fit the counters");
  end

  localparam logic [CNT_W-1:0]  TRIG_MIN   = CNT_W'(MIN_TRIG_CYC);
  localparam logic [CNT_W-1:0]  TRIG_MAX   = CNT_W'(MAX_TRIG_CYC);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0]  INCH_LAST  = CNT_W'(CYC_PER_INCH - 1);
  localparam logic [CNT_W-1:0]  REC_LAST   = CNT_W'(RECOVER_CYC - 1);
  localparam logic [INCH_W-1:0] MAX_D      = INCH_W'(MAX_INCH);

  // Saturate the requested distance into 1..MAX_INCH.
  function automatic logic [INCH_W-1:0] clamp_inch(input logic [INCH_W-1:0] d);
    if (d == '0)
      return INCH_W'(1);
    else if (d > MAX_D)
      return MAX_D;
    else
      return d;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [INCH_W-1:0] inch, inch_nxt;
  logic              bad_strobe, bad_nxt;
  logic              drive_en, drive_val;
  logic              level, rise, fall;
`ifdef PING_RESP_OUTRANGE_EN
  localparam logic [CNT_W-1:0] NOOBJ_LAST = CNT_W'(NO_OBJ_CYC - 1);
  logic              no_obj, no_obj_nxt;
`endif

  ping_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.pulse_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // State, counters and the bad-trigger strobe register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      inch       <= '0;
      bad_strobe <= 1'b0;
`ifdef PING_RESP_OUTRANGE_EN
      no_obj     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      inch       <= inch_nxt;
      bad_strobe <= bad_nxt;
`ifdef PING_RESP_OUTRANGE_EN
      no_obj     <= no_obj_nxt;
`endif
    end
  end

  // Next-state, counter updates and pin drive; the pin is ignored while driving.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inch_nxt  = inch;
    bad_nxt   = 1'b0;
    drive_en  = 1'b0;
    drive_val = 1'b0;
`ifdef PING_RESP_OUTRANGE_EN
    no_obj_nxt = no_obj;
`endif
    case (state)
      IDLE: begin
        if (rise && bus.enable) begin
          state_nxt = TRIG;
          cnt_nxt   = CNT_W'(1);
        end
      end
      TRIG: begin
        if (fall) begin
          cnt_nxt = '0;
          if (cnt >= TRIG_MIN && cnt <= TRIG_MAX) begin
            state_nxt = HOLDOFF;
            inch_nxt  = clamp_inch(bus.distance);
`ifdef PING_RESP_OUTRANGE_EN
            no_obj_nxt = (bus.distance > MAX_D);
`endif
          end else begin
            state_nxt = IDLE;
            bad_nxt   = 1'b1;
          end
        end else if (cnt > TRIG_MAX) begin
          state_nxt = WAITLOW;
          cnt_nxt   = '0;
          bad_nxt   = 1'b1;
        end else if (level) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAITLOW: begin
        if (!level) state_nxt = IDLE;
      end
      HOLDOFF: begin
        drive_en = 1'b1;
        if (cnt == HOLD_LAST) begin
          state_nxt = ECHO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ECHO: begin
        drive_en  = 1'b1;
        drive_val = 1'b1;
`ifdef PING_RESP_OUTRANGE_EN
        if (no_obj) begin
          if (cnt == NOOBJ_LAST) begin
            state_nxt = RECOVER;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else
`endif
        begin
          if (cnt == INCH_LAST) begin
            cnt_nxt = '0;
            if (inch == INCH_W'(1))
              state_nxt = RECOVER;
            else
              inch_nxt = inch - INCH_W'(1);
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      RECOVER: begin
        drive_en = 1'b1;
        if (cnt == REC_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.pulse_en  = drive_en;
  assign bus.pulse_out = drive_val;
  assign bus.busy      = (state == HOLDOFF) || (state == ECHO) || (state == RECOVER);
  assign bus.bad_trig  = bad_strobe;

endmodule

// File: tb/tb_ping_responder.sv
// Scoreboard bench for ping_responder: stimulus queues the expected
// holdoff/echo/recover widths (or a bad-trigger event); a negedge monitor
// measures every response on the pin and compares against the queue.
module tb_ping_responder;

  localparam int K_ECHO  = 0;
  localparam int K_BAD   = 1;
  localparam int K_ABORT = 2;
  localparam int K_NONE  = 3;
`ifdef PING_RESP_OUTRANGE_EN
  localparam int EXP_255 = 7227;
`else
  localparam int EXP_255 = 11600;
`endif

  typedef struct {
    int kind;
    int h;
    int e;
    int r;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic host_drv = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  int   mon_phase = 0;
  int   mh, me, mr;
  int   bad_run = 0;
  logic busy_lost = 1'b0;
  exp_t cur;

  ping_responder_if bus ();

  assign bus.pulse_in = bus.pulse_en ? bus.pulse_out : host_drv;

  ping_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_txn();
    check("holdoff_cycles", mh, cur.h);
    check("echo_cycles", me, cur.e);
    check("recover_cycles", mr, cur.r);
    check("busy_during_drive", int'(busy_lost), 0);
    check("busy_after_release", int'(bus.busy), 0);
    mon_phase = 0;
  endtask

  // Monitor: measure each pin response and bad-trigger strobe, compare to queue.
  always @(negedge clk) begin
    if (bus.bad_trig) begin
      if (bad_run == 0) begin
        if (q.size() == 0) begin
          check("unexpected_bad_trig", 1, 0);
        end else begin
          cur = q.pop_front();
          check("bad_trig_expected", cur.kind, K_BAD);
        end
      end
      bad_run++;
    end else if (bad_run > 0) begin
      check("bad_trig_width", bad_run, 1);
      bad_run = 0;
    end

    if (mon_phase != 0 && bus.pulse_en && !bus.busy) busy_lost = 1'b1;

    case (mon_phase)
      0: if (bus.pulse_en) begin
        if (q.size() == 0) begin
          check("unexpected_pulse_en", 1, 0);
          cur = '{K_NONE, 0, 0, 0};
        end else begin
          cur = q.pop_front();
          check("echo_expected", int'(cur.kind != K_BAD), 1);
        end
        busy_lost = !bus.busy;
        mh = 0; me = 0; mr = 0;
        if (bus.pulse_out) begin me = 1; mon_phase = 2; end
        else begin mh = 1; mon_phase = 1; end
      end
      1: if (!bus.pulse_en) finish_txn();
         else if (bus.pulse_out) begin me = 1; mon_phase = 2; end
         else mh++;
      2: if (!bus.pulse_en) finish_txn();
         else if (!bus.pulse_out) begin mr = 1; mon_phase = 3; end
         else me++;
      3: if (!bus.pulse_en) finish_txn();
         else if (bus.pulse_out) begin
           check("second_echo_in_recover", 1, 0);
           mr++;
         end else mr++;
      default: mon_phase = 0;
    endcase
  end

  task automatic trig(input int n);
    @(negedge clk);
    host_drv = 1'b1;
    repeat (n) @(negedge clk);
    host_drv = 1'b0;
  endtask

  task automatic push_echo(input int ecyc);
    q.push_back('{K_ECHO, 293, ecyc, 78});
  endtask

  task automatic wait_done(input string name, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q.size() == 0 && mon_phase == 0 && bad_run == 0 && !bus.busy) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    int busy_seen;
    bus.enable   = 1'b1;
    bus.distance = 8'd10;
    repeat (4) @(negedge clk);
    check("reset_pulse_en", int'(bus.pulse_en), 0);
    check("reset_pulse_out", int'(bus.pulse_out), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_bad_trig", int'(bus.bad_trig), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal 10-inch echo; pin seen low at the first edge after release,
    // fall strobe one edge later, HOLDOFF entered the edge after that.
    push_echo(580);
    trig(2);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (bus.pulse_en) break;
    end
    check("pulse_en_latency", n, 3);
    check("busy_at_accept", int'(bus.busy), 1);
    wait_done("done_d10", 2000);

    bus.distance = 8'd0;
    push_echo(58);
    trig(2);
    wait_done("done_d0", 2000);

    bus.distance = 8'd255;
    push_echo(EXP_255);
    trig(2);
    wait_done("done_d255", 15000);

    bus.distance = 8'd200;
    push_echo(11600);
    trig(1);
    wait_done("done_d200_w1", 15000);

    // Over-long trigger, then width-9 and width-8 boundaries.
    bus.distance = 8'd10;
    q.push_back('{K_BAD, 0, 0, 0});
    trig(12);
    wait_done("done_long_trig", 100);
    push_echo(580);
    trig(2);
    wait_done("done_after_bad", 2000);
    q.push_back('{K_BAD, 0, 0, 0});
    trig(9);
    wait_done("done_w9", 100);
    bus.distance = 8'd3;
    push_echo(174);
    trig(8);
    wait_done("done_w8", 2000);

    // Disabled responder ignores a valid trigger.
    bus.enable = 1'b0;
    busy_seen = 0;
    trig(2);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.busy || bus.pulse_en) busy_seen = 1;
    end
    check("disabled_no_response", busy_seen, 0);
    bus.enable = 1'b1;

    // Reset 101 echo-high samples into the echo.
    bus.distance = 8'd10;
    q.push_back('{K_ABORT, 293, 101, 0});
    trig(2);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.pulse_out) begin n = 1; break; end
    end
    check("echo_started", n, 1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pulse_en", int'(bus.pulse_en), 0);
    check("abort_pulse_out", int'(bus.pulse_out), 0);
    check("abort_busy", int'(bus.busy), 0);
    reset = 1'b0;
    wait_done("done_abort", 50);

    // Distance change during holdoff must not affect the echo.
    push_echo(580);
    trig(2);
    repeat (50) @(negedge clk);
    bus.distance = 8'd50;
    wait_done("done_dist_change", 2000);

    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
